c2c_data_arbiter: RTL and testbench

//  Shares one core-to-cache data port between two requesters: req0 (core LSU)
//  and req1 (secondary master, e.g. page-table walker or debug).

---
 rtl/c2c_data_arbiter.sv | 168 ++++++++++++++++
 tb/tb_c2c_data_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c2c_data_arbiter.sv
// c2c_data_arbiter: shares one core-to-cache data port between two requesters.
// Arbitration is round-robin with a registered grant and one access in flight.
// An LR reservation locks the port to its owner until SC/AMO/plain access or timeout.
`timescale 1ns/1ps
module c2c_data_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned LOCK_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    // requester 0
    input  logic                req0_re,
    input  logic                req0_we,
    input  logic                req0_atomic,
    input  logic [4:0]          req0_amo_op,
    input  logic [XLEN/8-1:0]   req0_sel,
    input  logic [XLEN-1:0]     req0_addr,
    input  logic [XLEN-1:0]     req0_data_w,
    output logic                req0_ack,
    output logic [XLEN-1:0]     req0_data_r,
    // requester 1
    input  logic                req1_re,
    input  logic                req1_we,
    input  logic                req1_atomic,
    input  logic [4:0]          req1_amo_op,
    input  logic [XLEN/8-1:0]   req1_sel,
    input  logic [XLEN-1:0]     req1_addr,
    input  logic [XLEN-1:0]     req1_data_w,
    output logic                req1_ack,
    output logic [XLEN-1:0]     req1_data_r,
    // downstream cache port
    output logic                cache_re,
    output logic                cache_we,
    output logic                cache_atomic,
    output logic [4:0]          cache_amo_op,
    output logic [XLEN/8-1:0]   cache_sel,
    output logic [XLEN-1:0]     cache_addr,
    output logic [XLEN-1:0]     cache_data_w,
    input  logic                cache_ack,
    input  logic [XLEN-1:0]     cache_data_r
);

    localparam int unsigned SEL_W = XLEN / 8;
    localparam int unsigned CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [4:0] AMO_LR = 5'b00010;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic             grant, grant_nxt;
    logic             rr_ptr, rr_ptr_nxt;
    logic             lock, lock_nxt;
    logic             owner, owner_nxt;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;

    logic [1:0]       req_valid;
    logic             busy;
    logic             g_re, g_we, g_atomic;
    logic [4:0]       g_amo_op;
    logic [SEL_W-1:0] g_sel;
    logic [XLEN-1:0]  g_addr, g_data_w;

    assign req_valid = {req1_re | req1_we, req0_re | req0_we};
    assign busy      = (state == BUSY);

    // Granted requester's request fields
    assign g_re     = grant ? req1_re     : req0_re;
    assign g_we     = grant ? req1_we     : req0_we;
    assign g_atomic = grant ? req1_atomic : req0_atomic;
    assign g_amo_op = grant ? req1_amo_op : req0_amo_op;
    assign g_sel    = grant ? req1_sel    : req0_sel;
    assign g_addr   = grant ? req1_addr   : req0_addr;
    assign g_data_w = grant ? req1_data_w : req0_data_w;

    // State, grant and lock registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= 1'b0;
            rr_ptr   <= 1'b0;
            lock     <= 1'b0;
            owner    <= 1'b0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            rr_ptr   <= rr_ptr_nxt;
            lock     <= lock_nxt;
            owner    <= owner_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Arbitration, completion and reservation-lock next-state logic
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        rr_ptr_nxt   = rr_ptr;
        lock_nxt     = lock;
        owner_nxt    = owner;
        lock_cnt_nxt = lock_cnt;
        case (state)
            IDLE: begin
                if (lock) begin
                    if (req_valid[owner]) begin
                        state_nxt    = BUSY;
                        grant_nxt    = owner;
                        lock_cnt_nxt = '0;
                    end else if (lock_cnt == CNT_LAST) begin
                        lock_nxt = 1'b0;
                    end else begin
                        lock_cnt_nxt = lock_cnt + CNT_W'(1);
                    end
                end else if (|req_valid) begin
                    state_nxt = BUSY;
                    grant_nxt = (&req_valid) ? rr_ptr : req_valid[1];
                end
            end
            BUSY: begin
                if (cache_ack) begin
                    state_nxt = IDLE;
                    if (!lock) begin
                        rr_ptr_nxt = ~grant;
                    end
                    if (g_atomic && (g_amo_op == AMO_LR)) begin
                        lock_nxt     = 1'b1;
                        owner_nxt    = grant;
                        lock_cnt_nxt = '0;
                    end else begin
                        lock_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Downstream request is driven only while an access is in flight
    always_comb begin
        cache_re     = 1'b0;
        cache_we     = 1'b0;
        cache_atomic = 1'b0;
        cache_amo_op = '0;
        cache_sel    = '0;
        cache_addr   = '0;
        cache_data_w = '0;
        if (busy) begin
            cache_re     = g_re;
            cache_we     = g_we;
            cache_atomic = g_atomic;
            cache_amo_op = g_amo_op;
            cache_sel    = g_sel;
            cache_addr   = g_addr;
            cache_data_w = g_data_w;
        end
    end

    // Ack only reaches the granted requester; read data is broadcast
    assign req0_ack    = cache_ack & ~grant & busy;
    assign req1_ack    = cache_ack &  grant & busy;
    assign req0_data_r = cache_data_r;
    assign req1_data_r = cache_data_r;

endmodule

// File: tb/tb_c2c_data_arbiter.sv
// Directed testbench for c2c_data_arbiter (LOCK_TIMEOUT=4).
`timescale 1ns/1ps
module tb_c2c_data_arbiter;

    localparam int unsigned XLEN = 32;

    logic              clk;
    logic              rst;
    logic              req0_re, req0_we, req0_atomic;
    logic [4:0]        req0_amo_op;
    logic [3:0]        req0_sel;
    logic [XLEN-1:0]   req0_addr, req0_data_w, req0_data_r;
    logic              req0_ack;
    logic              req1_re, req1_we, req1_atomic;
    logic [4:0]        req1_amo_op;
    logic [3:0]        req1_sel;
    logic [XLEN-1:0]   req1_addr, req1_data_w, req1_data_r;
    logic              req1_ack;
    logic              cache_re, cache_we, cache_atomic;
    logic [4:0]        cache_amo_op;
    logic [3:0]        cache_sel;
    logic [XLEN-1:0]   cache_addr, cache_data_w, cache_data_r;
    logic              cache_ack;

    int tests;
    int fails;

    c2c_data_arbiter #(.XLEN(XLEN), .LOCK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req0_re(req0_re), .req0_we(req0_we), .req0_atomic(req0_atomic),
        .req0_amo_op(req0_amo_op), .req0_sel(req0_sel), .req0_addr(req0_addr),
        .req0_data_w(req0_data_w), .req0_ack(req0_ack), .req0_data_r(req0_data_r),
        .req1_re(req1_re), .req1_we(req1_we), .req1_atomic(req1_atomic),
        .req1_amo_op(req1_amo_op), .req1_sel(req1_sel), .req1_addr(req1_addr),
        .req1_data_w(req1_data_w), .req1_ack(req1_ack), .req1_data_r(req1_data_r),
        .cache_re(cache_re), .cache_we(cache_we), .cache_atomic(cache_atomic),
        .cache_amo_op(cache_amo_op), .cache_sel(cache_sel), .cache_addr(cache_addr),
        .cache_data_w(cache_data_w), .cache_ack(cache_ack), .cache_data_r(cache_data_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2ns after the next rising edge
    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_req0();
        req0_re = 1'b0; req0_we = 1'b0; req0_atomic = 1'b0; req0_amo_op = 5'd0;
        req0_sel = 4'h0; req0_addr = '0; req0_data_w = '0;
    endtask

    task automatic clr_req1();
        req1_re = 1'b0; req1_we = 1'b0; req1_atomic = 1'b0; req1_amo_op = 5'd0;
        req1_sel = 4'h0; req1_addr = '0; req1_data_w = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        clr_req0();
        clr_req1();
        cache_ack = 1'b0;
        cache_data_r = '0;
        #3;
        chk("rst_cache_re", 32'(cache_re), 32'h0);
        chk("rst_cache_we", 32'(cache_we), 32'h0);
        chk("rst_cache_addr", cache_addr, 32'h0);
        chk("rst_ack0", 32'(req0_ack), 32'h0);
        chk("rst_ack1", 32'(req1_ack), 32'h0);
        chk("rst_state", 32'(dut.state), 32'h0);
        chk("rst_rr_ptr", 32'(dut.rr_ptr), 32'h0);
        chk("rst_lock", 32'(dut.lock), 32'h0);
        nxt();
        rst = 1'b0;

        // Single requester read, cache acks in the third busy cycle
        req0_re = 1'b1; req0_addr = 32'h1000; req0_sel = 4'hF;
        #1;
        chk("single_idle_re", 32'(cache_re), 32'h0);
        nxt(); #1;
        chk("single_busy_re", 32'(cache_re), 32'h1);
        chk("single_addr", cache_addr, 32'h1000);
        chk("single_sel", 32'(cache_sel), 32'hF);
        chk("single_ack0_early", 32'(req0_ack), 32'h0);
        nxt(); #1;
        chk("single_ack0_wait", 32'(req0_ack), 32'h0);
        nxt();
        cache_ack = 1'b1; cache_data_r = 32'hDEADBEEF;
        #1;
        chk("single_ack0", 32'(req0_ack), 32'h1);
        chk("single_data_r", req0_data_r, 32'hDEADBEEF);
        chk("single_ack1", 32'(req1_ack), 32'h0);
        nxt();
        clr_req0();
        cache_ack = 1'b0;
        #1;
        chk("single_done_re", 32'(cache_re), 32'h0);
        chk("single_done_ack0", 32'(req0_ack), 32'h0);

        // Stray cache ack while idle
        nxt();
        cache_ack = 1'b1;
        #1;
        chk("stray_ack0", 32'(req0_ack), 32'h0);
        chk("stray_ack1", 32'(req1_ack), 32'h0);
        nxt();
        cache_ack = 1'b0;
        #1;
        chk("stray_state", 32'(dut.state), 32'h0);

        // Contention from reset: order 0,1,0,1
        do_reset();
        req0_we = 1'b1; req0_addr = 32'h100; req0_data_w = 32'hA0; req0_sel = 4'hF;
        req1_we = 1'b1; req1_addr = 32'h200; req1_data_w = 32'hB1; req1_sel = 4'h3;
        for (int i = 0; i < 4; i++) begin
            bit eg;
            eg = ((i % 2) == 1);
            #1;
            chk("cont_idle_we", 32'(cache_we), 32'h0);
            nxt();
            cache_ack = 1'b1;
            #1;
            chk("cont_we", 32'(cache_we), 32'h1);
            chk("cont_addr", cache_addr, eg ? 32'h200 : 32'h100);
            chk("cont_data_w", cache_data_w, eg ? 32'hB1 : 32'hA0);
            chk("cont_ack0", 32'(req0_ack), eg ? 32'h0 : 32'h1);
            chk("cont_ack1", 32'(req1_ack), eg ? 32'h1 : 32'h0);
            nxt();
            cache_ack = 1'b0;
        end
        clr_req0();
        clr_req1();
        #1;
        chk("cont_end_we", 32'(cache_we), 32'h0);
        chk("cont_end_rr", 32'(dut.rr_ptr), 32'h0);
        nxt();

        // Back-to-back reads from req1, 1-cycle cache ack
        for (int i = 0; i < 3; i++) begin
            req1_re = 1'b1; req1_addr = 32'h300 + 32'(4 * i); req1_sel = 4'hF;
            #1;
            chk("b2b_idle_re", 32'(cache_re), 32'h0);
            nxt();
            cache_ack = 1'b1; cache_data_r = 32'h11110000 + 32'(i);
            #1;
            chk("b2b_re", 32'(cache_re), 32'h1);
            chk("b2b_addr", cache_addr, 32'h300 + 32'(4 * i));
            chk("b2b_ack1", 32'(req1_ack), 32'h1);
            chk("b2b_data_r", req1_data_r, 32'h11110000 + 32'(i));
            chk("b2b_ack0", 32'(req0_ack), 32'h0);
            nxt();
            cache_ack = 1'b0;
        end
        clr_req1();
        #1;
        chk("b2b_end_re", 32'(cache_re), 32'h0);
        nxt();

        // LR/SC: req1 write to the same address stalls until SC acks
        req0_re = 1'b1; req0_atomic = 1'b1; req0_amo_op = 5'b00010;
        req0_addr = 32'h400; req0_sel = 4'hF;
        req1_we = 1'b1; req1_addr = 32'h400; req1_data_w = 32'h55; req1_sel = 4'hF;
        #1;
        chk("lr_idle_re", 32'(cache_re), 32'h0);
        nxt();
        cache_ack = 1'b1; cache_data_r = 32'h1234;
        #1;
        chk("lr_re", 32'(cache_re), 32'h1);
        chk("lr_we", 32'(cache_we), 32'h0);
        chk("lr_amo", 32'(cache_amo_op), 32'h2);
        chk("lr_ack0", 32'(req0_ack), 32'h1);
        chk("lr_ack1", 32'(req1_ack), 32'h0);
        nxt();
        cache_ack = 1'b0;
        req0_re = 1'b0; req0_we = 1'b1; req0_amo_op = 5'b00011; req0_data_w = 32'h77;
        #1;
        chk("sc_lock_set", 32'(dut.lock), 32'h1);
        chk("sc_idle_we", 32'(cache_we), 32'h0);
        nxt(); #1;
        chk("sc_data_w", cache_data_w, 32'h77);
        chk("sc_amo", 32'(cache_amo_op), 32'h3);
        chk("sc_rr_ptr", 32'(dut.rr_ptr), 32'h1);
        nxt();
        cache_ack = 1'b1;
        #1;
        chk("sc_ack0", 32'(req0_ack), 32'h1);
        chk("sc_ack1", 32'(req1_ack), 32'h0);
        nxt();
        cache_ack = 1'b0;
        clr_req0();
        #1;
        chk("sc_lock_clr", 32'(dut.lock), 32'h0);
        chk("sc_rr_hold", 32'(dut.rr_ptr), 32'h1);
        chk("sc_post_idle_we", 32'(cache_we), 32'h0);
        nxt();
        cache_ack = 1'b1;
        #1;
        chk("w1_we", 32'(cache_we), 32'h1);
        chk("w1_data_w", cache_data_w, 32'h55);
        chk("w1_ack1", 32'(req1_ack), 32'h1);
        nxt();
        cache_ack = 1'b0;
        clr_req1();

        // Lock timeout: owner goes silent after LR, req1 waits
        req0_re = 1'b1; req0_atomic = 1'b1; req0_amo_op = 5'b00010;
        req0_addr = 32'h500; req0_sel = 4'hF;
        #1;
        chk("to_idle_re", 32'(cache_re), 32'h0);
        nxt();
        cache_ack = 1'b1;
        req1_we = 1'b1; req1_addr = 32'h600; req1_data_w = 32'h66; req1_sel = 4'hF;
        #1;
        chk("to_lr_ack0", 32'(req0_ack), 32'h1);
        chk("to_lr_ack1", 32'(req1_ack), 32'h0);
        nxt();
        cache_ack = 1'b0;
        clr_req0();
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("to_locked", 32'(dut.lock), 32'h1);
            chk("to_hold_we", 32'(cache_we), 32'h0);
            nxt();
        end
        #1;
        chk("to_unlocked", 32'(dut.lock), 32'h0);
        chk("to_grant_idle_we", 32'(cache_we), 32'h0);
        nxt();
        cache_ack = 1'b1;
        #1;
        chk("to_we", 32'(cache_we), 32'h1);
        chk("to_addr", cache_addr, 32'h600);
        chk("to_ack1", 32'(req1_ack), 32'h1);
        nxt();
        cache_ack = 1'b0;
        clr_req1();

        // Async reset mid-access: first move rr_ptr to 1
        req0_re = 1'b1; req0_addr = 32'h700; req0_sel = 4'hF;
        nxt();
        cache_ack = 1'b1;
        nxt();
        cache_ack = 1'b0;
        clr_req0();
        req1_re = 1'b1; req1_addr = 32'h800; req1_sel = 4'hF;
        #1;
        chk("ar_rr_before", 32'(dut.rr_ptr), 32'h1);
        nxt();
        cache_ack = 1'b1;
        #1;
        chk("ar_busy_re", 32'(cache_re), 32'h1);
        chk("ar_busy_ack1", 32'(req1_ack), 32'h1);
        rst = 1'b1;
        #1;
        chk("ar_re", 32'(cache_re), 32'h0);
        chk("ar_we", 32'(cache_we), 32'h0);
        chk("ar_ack0", 32'(req0_ack), 32'h0);
        chk("ar_ack1", 32'(req1_ack), 32'h0);
        rst = 1'b0;
        cache_ack = 1'b0;
        clr_req1();
        #1;
        chk("ar_rr_after", 32'(dut.rr_ptr), 32'h0);
        chk("ar_state_after", 32'(dut.state), 32'h0);
        nxt();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
